// File: rtl/uart_fifo_core.sv
// uart_fifo_core: UART with TX/RX FIFOs, valid/ready host side, sticky errors.
// Optional feature macro: UART_PARITY_EN (even parity bit after the data bits).
// Without the macro the frame is start + DATA_WIDTH data + STOP_BITS stop.

module uart_fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    // a pop frees the slot, so a push into a full FIFO is allowed alongside it
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // pointers wrap naturally at the power-of-two depth; level tracks 0..DEPTH
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_wr) - LW'(do_rd);
        end
    end

    // storage needs no reset; only the pointers define contents
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

module uart_fifo_core #(
    parameter int          DATA_WIDTH       = 8,
    parameter int          FIFO_DEPTH       = 16,
    parameter int          STOP_BITS        = 1,
    parameter logic [15:0] DEFAULT_PRESCALE = 16'd434,
    localparam int         LW               = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           prescale,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  txd,
    input  logic                  rxd,
    output logic                  tx_busy,
    output logic                  rx_busy,
    output logic [LW-1:0]         tx_level,
    output logic [LW-1:0]         rx_level,
    output logic                  rx_overrun,
    output logic                  frame_err,
    output logic                  parity_err,
    input  logic                  err_clr
);
    localparam int BW = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [15:0] p_eff;
    assign p_eff = (prescale == 16'd0) ? DEFAULT_PRESCALE : prescale;

    // ---------------- TX ----------------
    state_t                tx_state, tx_state_nx;
    logic [15:0]           tx_cnt, tx_p;
    logic [DATA_WIDTH-1:0] tx_shift, tx_head;
    logic [BW-1:0]         tx_bit_idx;
    logic                  tx_stop_idx;
    logic                  tx_tick, tx_load, txd_nx;
    logic                  tx_full, tx_empty;
`ifdef UART_PARITY_EN
    logic                  tx_par;
`endif

    assign tx_ready = !tx_full;
    assign tx_tick  = (tx_cnt == 16'd0);
    assign tx_busy  = (tx_state != S_IDLE) || !tx_empty;

    uart_fifo_sync #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n),
        .wr_en(tx_valid && tx_ready), .wr_data(tx_data),
        .rd_en(tx_load), .rd_data(tx_head),
        .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    // TX state register
    always_ff @(posedge clk) begin
        if (!rst_n) tx_state <= S_IDLE;
        else        tx_state <= tx_state_nx;
    end

    // TX next state: STOP chains straight into START when more words wait
    always_comb begin
        tx_state_nx = tx_state;
        case (tx_state)
            S_IDLE:  if (!tx_empty) tx_state_nx = S_START;
            S_START: if (tx_tick) tx_state_nx = S_DATA;
            S_DATA:  if (tx_tick && tx_bit_idx == BW'(DATA_WIDTH-1))
`ifdef UART_PARITY_EN
                         tx_state_nx = S_PARITY;
            S_PARITY: if (tx_tick) tx_state_nx = S_STOP;
`else
                         tx_state_nx = S_STOP;
`endif
            S_STOP:  if (tx_tick && tx_stop_idx == 1'(STOP_BITS-1))
                         tx_state_nx = tx_empty ? S_IDLE : S_START;
            default: tx_state_nx = S_IDLE;
        endcase
    end

    // TX outputs: line level per state, and the pop/load strobe on entering START
    always_comb begin
        txd_nx = 1'b1;
        case (tx_state)
            S_START:  txd_nx = 1'b0;
            S_DATA:   txd_nx = tx_shift[0];
`ifdef UART_PARITY_EN
            S_PARITY: txd_nx = tx_par;
`endif
            default:  txd_nx = 1'b1;
        endcase
        tx_load = (tx_state_nx == S_START) && (tx_state != S_START);
    end

    // TX datapath: bit timer, shifter, and the registered line driver
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            txd         <= 1'b1;
            tx_cnt      <= '0;
            tx_p        <= '0;
            tx_shift    <= '0;
            tx_bit_idx  <= '0;
            tx_stop_idx <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par      <= 1'b0;
`endif
        end else begin
            txd <= txd_nx;
            if (tx_load) begin
                tx_p        <= p_eff;
                tx_cnt      <= p_eff - 16'd1;
                tx_shift    <= tx_head;
                tx_bit_idx  <= '0;
                tx_stop_idx <= 1'b0;
`ifdef UART_PARITY_EN
                tx_par      <= ^tx_head;
`endif
            end else if (tx_state != S_IDLE) begin
                if (tx_tick) begin
                    tx_cnt <= tx_p - 16'd1;
                    if (tx_state == S_DATA) begin
                        tx_shift   <= tx_shift >> 1;
                        tx_bit_idx <= tx_bit_idx + 1'b1;
                    end
                    if (tx_state == S_STOP) tx_stop_idx <= tx_stop_idx + 1'b1;
                end else begin
                    tx_cnt <= tx_cnt - 16'd1;
                end
            end
        end
    end

    // ---------------- RX ----------------
    state_t                rx_state, rx_state_nx;
    logic [1:0]            rx_sync;
    logic                  rxs;
    logic [15:0]           rx_cnt, rx_p;
    logic [DATA_WIDTH-1:0] rx_shift;
    logic [BW-1:0]         rx_bit_idx;
    logic                  rx_hold;
    logic                  rx_tick, rx_stop_tick, rx_push, par_bad;
    logic                  frame_set, overrun_set;
    logic                  rx_full, rx_empty;
`ifdef UART_PARITY_EN
    logic                  rx_par_bit;
`endif

    assign rxs      = rx_sync[1];
    assign rx_tick  = (rx_cnt == 16'd0);
    assign rx_busy  = (rx_state != S_IDLE);
    assign rx_valid = !rx_empty;

    uart_fifo_sync #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n),
        .wr_en(rx_push), .wr_data(rx_shift),
        .rd_en(rx_ready), .rd_data(rx_data),
        .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    // two-flop synchroniser, parked at the idle level
    always_ff @(posedge clk) begin
        if (!rst_n) rx_sync <= 2'b11;
        else        rx_sync <= {rx_sync[0], rxd};
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (!rst_n) rx_state <= S_IDLE;
        else        rx_state <= rx_state_nx;
    end

    // RX next state: a start that reads high at mid-bit is a glitch
    always_comb begin
        rx_state_nx = rx_state;
        case (rx_state)
            S_IDLE:  if (!rxs && !rx_hold) rx_state_nx = S_START;
            S_START: if (rx_tick) rx_state_nx = rxs ? S_IDLE : S_DATA;
            S_DATA:  if (rx_tick && rx_bit_idx == BW'(DATA_WIDTH-1))
`ifdef UART_PARITY_EN
                         rx_state_nx = S_PARITY;
            S_PARITY: if (rx_tick) rx_state_nx = S_STOP;
`else
                         rx_state_nx = S_STOP;
`endif
            S_STOP:  if (rx_tick) rx_state_nx = S_IDLE;
            default: rx_state_nx = S_IDLE;
        endcase
    end

    // RX outputs: push/error strobes at the stop-bit sample
    always_comb begin
        rx_stop_tick = (rx_state == S_STOP) && rx_tick;
        frame_set    = rx_stop_tick && !rxs;
        par_bad      = 1'b0;
`ifdef UART_PARITY_EN
        par_bad      = rx_par_bit != ^rx_shift;
`endif
        rx_push      = rx_stop_tick && rxs && !par_bad;
        // a same-cycle pop makes room, so only a non-popping full FIFO overruns
        overrun_set  = rx_push && rx_full && !rx_ready;
    end

    // RX datapath: half-bit first delay, then whole-bit sample spacing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_cnt     <= '0;
            rx_p       <= '0;
            rx_shift   <= '0;
            rx_bit_idx <= '0;
            rx_hold    <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_bit <= 1'b0;
`endif
        end else if (rx_state == S_IDLE) begin
            if (rxs) rx_hold <= 1'b0;
            if (rx_state_nx == S_START) begin
                rx_p       <= p_eff;
                rx_cnt     <= (p_eff[15:1] == 15'd0) ? 16'd0 : (p_eff >> 1) - 16'd1;
                rx_bit_idx <= '0;
            end
        end else if (rx_tick) begin
            rx_cnt <= rx_p - 16'd1;
            if (rx_state == S_DATA) begin
                rx_shift   <= {rxs, rx_shift[DATA_WIDTH-1:1]};
                rx_bit_idx <= rx_bit_idx + 1'b1;
            end
`ifdef UART_PARITY_EN
            if (rx_state == S_PARITY) rx_par_bit <= rxs;
`endif
            // after a bad stop the line must return high before a new start
            if (frame_set) rx_hold <= 1'b1;
        end else begin
            rx_cnt <= rx_cnt - 16'd1;
        end
    end

    // sticky error flags; a set in the clearing cycle wins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_overrun <= overrun_set | (rx_overrun & ~err_clr);
            frame_err  <= frame_set | (frame_err & ~err_clr);
        end
    end

`ifdef UART_PARITY_EN
    // parity flag, same sticky rule as the others
    always_ff @(posedge clk) begin
        if (!rst_n) parity_err <= 1'b0;
        else        parity_err <= (rx_stop_tick && par_bad) | (parity_err & ~err_clr);
    end
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: directed sequence with random payloads, txd decoded
// by a behavioural line monitor, RX contents predicted with a queue model.
module tb_uart_fifo_core;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int LW    = 5;
`ifdef UART_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = 1 + DW + PAR + 1;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [15:0]   prescale = 16'd4;
    logic [DW-1:0] tx_data = '0, rx_data;
    logic          tx_valid = 1'b0, tx_ready, rx_valid, rx_ready = 1'b0;
    logic          txd, rxd, tx_busy, rx_busy;
    logic [LW-1:0] tx_level, rx_level;
    logic          rx_overrun, frame_err, parity_err, err_clr = 1'b0;
    logic          loop_en = 1'b0, rxd_drv = 1'b1;

    assign rxd = loop_en ? txd : rxd_drv;

    uart_fifo_core #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .prescale(prescale),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .txd(txd), .rxd(rxd), .tx_busy(tx_busy), .rx_busy(rx_busy),
        .tx_level(tx_level), .rx_level(rx_level),
        .rx_overrun(rx_overrun), .frame_err(frame_err), .parity_err(parity_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // behavioural txd decoder: mid-bit sampling from the observed falling edge
    int            mon_p = 4;
    logic [DW-1:0] mon_words[$];
    int            mon_t[$];
    bit            mon_ok[$];
    initial begin : tx_mon
        int t0;
        logic [DW-1:0] w;
        bit ok;
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                t0 = cyc;
                ok = 1'b1;
                repeat (mon_p / 2) @(negedge clk);
                if (txd !== 1'b0) ok = 1'b0;
                for (int i = 0; i < DW; i++) begin
                    repeat (mon_p) @(negedge clk);
                    w[i] = txd;
                end
                if (PAR != 0) begin
                    repeat (mon_p) @(negedge clk);
                    if (txd !== ^w) ok = 1'b0;
                end
                repeat (mon_p) @(negedge clk);
                if (txd !== 1'b1) ok = 1'b0;
                mon_words.push_back(w);
                mon_t.push_back(t0);
                mon_ok.push_back(ok);
            end
        end
    end

    task automatic mon_clear();
        mon_words.delete();
        mon_t.delete();
        mon_ok.delete();
    endtask

    // one word through the TX handshake, bounded wait for tx_ready
    task automatic send_word(input logic [DW-1:0] w);
        int guard = 0;
        tx_data  = w;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("send_word_ready", 32'(guard < 2000), 1);
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // tx_valid held over n_iter cycles while presenting sw[] in order
    logic [DW-1:0] sw [32];
    task automatic stream(input int n_words, input int n_iter, output int acc);
        logic take;
        acc = 0;
        tx_data = sw[0];
        for (int c = 0; c < n_iter; c++) begin
            tx_valid = (acc < n_words);
            take = tx_ready && (acc < n_words);
            @(negedge clk);
            if (take) acc++;
            tx_data = sw[acc];
        end
        tx_valid = 1'b0;
    endtask

    // hand-built frame on rxd, with a chosen stop level and optional bad parity
    task automatic send_serial(input logic [DW-1:0] w, input int p, input logic stop_v,
                               input logic par_flip);
        rxd_drv = 1'b0;
        tick(p);
        for (int i = 0; i < DW; i++) begin
            rxd_drv = w[i];
            tick(p);
        end
        if (PAR != 0) begin
            rxd_drv = (^w) ^ par_flip;
            tick(p);
        end
        rxd_drv = stop_v;
        tick(p);
        rxd_drv = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [DW-1:0] exp);
        chk({tag, "_valid"}, 32'(rx_valid), 1);
        chk({tag, "_data"}, 32'(rx_data), 32'(exp));
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic wait_rx_valid(input string tag, input int bound);
        int guard = 0;
        while (rx_valid !== 1'b1 && guard < bound) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_rx_timeout"}, 32'(guard < bound), 1);
    endtask

    task automatic wait_mon(input string tag, input int n, input int bound);
        int guard = 0;
        while (mon_words.size() < n && guard < bound) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_mon_timeout"}, 32'(guard < bound), 1);
    endtask

    initial begin : main
        int acc, guard, low_run;
        logic [DW-1:0] rx_model[$];
        bit ovr_exp;
        logic [DW-1:0] w;

        // ---- reset state
        tick(3);
        chk("rst_txd", 32'(txd), 1);
        chk("rst_tx_ready", 32'(tx_ready), 1);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_tx_level", 32'(tx_level), 0);
        chk("rst_rx_level", 32'(rx_level), 0);
        chk("rst_flags", {29'd0, rx_overrun, frame_err, parity_err}, 0);
        chk("rst_busy", {30'd0, tx_busy, rx_busy}, 0);
        rst_n = 1'b1;
        tick(2);

        // ---- 1: 0xA5 at P=4, exact start latency, prescale change mid-frame
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        chk("t1_txd_edge1", 32'(txd), 1);
        @(negedge clk);
        chk("t1_txd_edge2", 32'(txd), 1);
        @(negedge clk);
        chk("t1_txd_start", 32'(txd), 0);
        chk("t1_busy_mid", 32'(tx_busy), 1);
        tick(14);
        prescale = 16'd8;
        wait_mon("t1", 1, 100);
        prescale = 16'd4;
        if (mon_words.size() > 0) begin
            chk("t1_word", 32'(mon_words[0]), 32'h A5);
            chk("t1_frame", 32'(mon_ok[0]), 1);
        end
        tick(5);
        chk("t1_busy_end", 32'(tx_busy), 0);
        chk("t1_txd_idle", 32'(txd), 1);
        mon_clear();

        // ---- 2: loopback at the default prescale
        prescale = 16'd0;
        mon_p    = 434;
        loop_en  = 1'b1;
        send_word(8'h3C);
        guard = 0;
        while (txd !== 1'b0 && guard < 100) begin @(negedge clk); guard++; end
        low_run = 0;
        while (txd === 1'b0 && low_run < 3000) begin @(negedge clk); low_run++; end
        chk("t2_low_run", low_run, 3 * 434);
        wait_rx_valid("t2", 12000);
        chk("t2_rx_data", 32'(rx_data), 32'h3C);
        chk("t2_rx_level", 32'(rx_level), 1);
        wait_mon("t2", 1, 2000);
        if (mon_words.size() > 0) chk("t2_mon_word", 32'(mon_words[0]), 32'h3C);
        pop_check("t2_pop", 8'h3C);
        chk("t2_empty", 32'(rx_level), 0);
        tick(500);
        loop_en = 1'b0;
        mon_clear();

        // ---- 3: 18 words offered with tx_valid held, DEPTH 16
        prescale = 16'd4;
        mon_p    = 4;
        for (int i = 0; i < 32; i++) sw[i] = DW'($urandom);
        stream(18, 20, acc);
        chk("t3_accepted", acc, DEPTH + 1);
        chk("t3_tx_level_full", 32'(tx_level), DEPTH);
        chk("t3_tx_ready_full", 32'(tx_ready), 0);
        wait_mon("t3", 17, 17 * FRAME * 4 + 200);
        for (int i = 0; i < 17 && i < mon_words.size(); i++) begin
            chk($sformatf("t3_word%0d", i), 32'(mon_words[i]), 32'(sw[i]));
            chk($sformatf("t3_frame%0d", i), 32'(mon_ok[i]), 1);
            if (i > 0) chk($sformatf("t3_gap%0d", i), mon_t[i] - mon_t[i-1], FRAME * 4);
        end
        tick(10);
        chk("t3_tx_idle", 32'(tx_busy), 0);
        mon_clear();

        // ---- 4: loopback into a FIFO nobody drains
        for (int i = 0; i < 32; i++) sw[i] = DW'($urandom);
        rx_model.delete();
        ovr_exp = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (rx_model.size() < DEPTH) rx_model.push_back(sw[i]);
            else ovr_exp = 1'b1;
        end
        loop_en = 1'b1;
        stream(17, 17, acc);
        chk("t4_accepted", acc, 17);
        wait_mon("t4", 17, 17 * FRAME * 4 + 200);
        tick(10);
        chk("t4_rx_level", 32'(rx_level), rx_model.size());
        chk("t4_overrun", 32'(rx_overrun), 32'(ovr_exp));
        chk("t4_head", 32'(rx_data), 32'(rx_model[0]));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_overrun_clr", 32'(rx_overrun), 0);
        while (rx_model.size() > 0) begin
            w = rx_model.pop_front();
            pop_check("t4_pop", w);
        end
        chk("t4_drained", 32'(rx_valid), 0);
        loop_en = 1'b0;
        mon_clear();

        // ---- 5: bad stop bit, then a short glitch, then a good word
        send_serial(8'h55, 4, 1'b0, 1'b0);
        tick(4);
        chk("t5_frame_err", 32'(frame_err), 1);
        chk("t5_no_push", 32'(rx_level), 0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t5_frame_clr", 32'(frame_err), 0);
        tick(4);
        rxd_drv = 1'b0;
        tick(1);
        rxd_drv = 1'b1;
        tick(20);
        chk("t5_glitch_flag", {30'd0, frame_err, parity_err}, 0);
        chk("t5_glitch_push", 32'(rx_level), 0);
        chk("t5_glitch_idle", 32'(rx_busy), 0);
        w = DW'($urandom);
        send_serial(w, 4, 1'b1, 1'b0);
        tick(4);
        chk("t5_good_level", 32'(rx_level), 1);
        pop_check("t5_good", w);
`ifdef UART_PARITY_EN
        send_serial(DW'($urandom), 4, 1'b1, 1'b1);
        tick(4);
        chk("t5_parity_err", 32'(parity_err), 1);
        chk("t5_parity_no_push", 32'(rx_level), 0);
`endif

        // ---- 6: reset in the middle of TX and RX frames
        send_serial(8'h55, 4, 1'b0, 1'b0);
        tick(4);
        chk("t6_pre_flag", 32'(frame_err), 1);
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) sw[i] = DW'($urandom);
        stream(3, 3, acc);
        tick(55);
        chk("t6_pre_rx_level", 32'(rx_level), 1);
        chk("t6_pre_tx_level", 32'(tx_level), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_txd", 32'(txd), 1);
        chk("t6_tx_level", 32'(tx_level), 0);
        chk("t6_rx_level", 32'(rx_level), 0);
        chk("t6_flags", {29'd0, rx_overrun, frame_err, parity_err}, 0);
        chk("t6_busy", {30'd0, tx_busy, rx_busy}, 0);
        chk("t6_ready", {30'd0, tx_ready, rx_valid}, 32'b10);
        rst_n = 1'b1;
        tick(60);
        mon_clear();
        send_word(8'h81);
        wait_rx_valid("t6", 200);
        chk("t6_rx_data", 32'(rx_data), 32'h81);
        chk("t6_rx_level_after", 32'(rx_level), 1);
        chk("t6_flags_after", {29'd0, rx_overrun, frame_err, parity_err}, 0);
        pop_check("t6_pop", 8'h81);
        loop_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
